// File: rtl/cache_stats_pkg.sv
// Shared constants for the cache statistics block: trace command codes
// and the per-channel counter index map (reads, writes, hits, misses).
package cache_stats_pkg;

  localparam logic [3:0] CMD_CLEAR = 4'd8;
  localparam logic [3:0] CMD_SNAP  = 4'd9;

  localparam int CNT_RD   = 0;
  localparam int CNT_WR   = 1;
  localparam int CNT_HIT  = 2;
  localparam int CNT_MISS = 3;
  localparam int NUM_CNT  = 4;

endpackage

// File: rtl/stat_counter.sv
// One live event counter with its snapshot copy and sticky overflow flag.
// STATS_SATURATE_EN: hold at all-ones on overflow instead of wrapping to 0.
module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] live_o,
  output logic [CNT_W-1:0] snap_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] live_q, live_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    live_d = live_q;
    snap_d = snap_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      // Clear drops any event arriving in the same cycle.
      live_d = '0;
      snap_d = '0;
      ovf_d  = 1'b0;
    end else begin
      // Snapshot captures the pre-increment value.
      if (snap_i) snap_d = live_q;
      if (inc_i) begin
        if (&live_q) begin
          ovf_d = 1'b1;
`ifdef STATS_SATURATE_EN
          live_d = live_q;
`else
          live_d = '0;
`endif
        end else begin
          live_d = live_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= '0;
      snap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      live_q <= live_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign live_o = live_q;
  assign snap_o = snap_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/cache_stats_counters.sv
// Per-channel read/write/hit/miss statistics with clear/snapshot commands
// and a registered snapshot readback port. STATS_SATURATE_EN selects
// saturating counters (see stat_counter).
// Readback handshake: rd_req sampled at an edge yields rd_ack high for
// exactly the following cycle with rd_data; no backpressure, one ack per req.
module cache_stats_counters
  import cache_stats_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  input  logic [3:0]                n,
  input  logic [NUM_CH-1:0]         rd,
  input  logic [NUM_CH-1:0]         wr,
  input  logic [NUM_CH-1:0]         hit,
  input  logic [NUM_CH-1:0]         miss,
  input  logic                      rd_req,
  input  logic [CH_W-1:0]           sel_ch,
  input  logic [1:0]                sel_cnt,
  output logic                      rd_ack,
  output logic [CNT_W-1:0]          rd_data,
  output logic                      snap_done,
  output logic [NUM_CH*NUM_CNT-1:0] ovf,
  output logic                      proto_err
);

  logic clr, snap;
  logic [CNT_W-1:0] snap_val    [NUM_CH][NUM_CNT];
  logic [CNT_W-1:0] unused_live [NUM_CH][NUM_CNT];
  logic [CNT_W-1:0] rd_mux;

  logic             rd_ack_q, rd_ack_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             snap_done_q, snap_done_d;
  logic             proto_err_q, proto_err_d;

  assign clr  = cmd_valid && (n == CMD_CLEAR);
  assign snap = cmd_valid && (n == CMD_SNAP);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_CNT-1:0] ev;
    assign ev[CNT_RD]   = rd[c];
    assign ev[CNT_WR]   = wr[c];
    assign ev[CNT_HIT]  = hit[c];
    assign ev[CNT_MISS] = miss[c];
    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
      stat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (ev[k]),
        .clr_i  (clr),
        .snap_i (snap),
        .live_o (unused_live[c][k]),
        .snap_o (snap_val[c][k]),
        .ovf_o  (ovf[c*NUM_CNT+k])
      );
    end
  end

  // Unmatched selections (sel_ch beyond NUM_CH) fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (sel_ch == CH_W'(c) && sel_cnt == 2'(k)) rd_mux = snap_val[c][k];
      end
    end
  end

  always_comb begin
    rd_ack_d    = rd_req;
    rd_data_d   = rd_req ? rd_mux : rd_data_q;
    snap_done_d = snap;
    proto_err_d = proto_err_q;
    if (clr)                proto_err_d = 1'b0;
    else if (|(hit & miss)) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      snap_done_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rd_ack_q    <= rd_ack_d;
      rd_data_q   <= rd_data_d;
      snap_done_q <= snap_done_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_ack    = rd_ack_q;
  assign rd_data   = rd_data_q;
  assign snap_done = snap_done_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cache_stats_counters.sv
// Directed bench for cache_stats_counters (NUM_CH=3, CNT_W=8) with an
// arithmetic reference model, a per-cycle compare and literal spot checks.
module tb_cache_stats_counters;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam int NCNT   = 4;
  localparam int unsigned MAXV = (1 << CNT_W) - 1;
`ifdef STATS_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [3:0] n = '0;
  logic [NUM_CH-1:0] rd = '0, wr = '0, hit = '0, miss = '0;
  logic rd_req = 1'b0;
  logic [CH_W-1:0] sel_ch = '0;
  logic [1:0] sel_cnt = '0;
  logic rd_ack;
  logic [CNT_W-1:0] rd_data;
  logic snap_done;
  logic [NUM_CH*NCNT-1:0] ovf;
  logic proto_err;

  int checks = 0;
  int errors = 0;

  cache_stats_counters #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .n(n),
    .rd(rd), .wr(wr), .hit(hit), .miss(miss),
    .rd_req(rd_req), .sel_ch(sel_ch), .sel_cnt(sel_cnt),
    .rd_ack(rd_ack), .rd_data(rd_data), .snap_done(snap_done),
    .ovf(ovf), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned live_m [NUM_CH][NCNT];
  int unsigned snap_m [NUM_CH][NCNT];
  bit [NUM_CH*NCNT-1:0] ovf_m;
  bit proto_m, snapd_m;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] last_data_m;

  function automatic bit event_of(int c, int k);
    case (k)
      0: return rd[c];
      1: return wr[c];
      2: return hit[c];
      default: return miss[c];
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    bit do_clr, do_snap;
    if (rst) begin
      foreach (live_m[c, k]) begin live_m[c][k] = 0; snap_m[c][k] = 0; end
      ovf_m = '0; proto_m = 0; snapd_m = 0;
      exp_q.delete();
    end else begin
      do_clr  = cmd_valid && (n == 4'd8);
      do_snap = cmd_valid && (n == 4'd9);
      if (rd_req)
        exp_q.push_back((int'(sel_ch) < NUM_CH) ? CNT_W'(snap_m[sel_ch][sel_cnt]) : '0);
      snapd_m = do_snap;
      if (do_clr) begin
        foreach (live_m[c, k]) begin live_m[c][k] = 0; snap_m[c][k] = 0; end
        ovf_m = '0; proto_m = 0;
      end else begin
        if (do_snap) foreach (live_m[c, k]) snap_m[c][k] = live_m[c][k];
        foreach (live_m[c, k]) begin
          if (event_of(c, k)) begin
            if (live_m[c][k] == MAXV) begin
              ovf_m[c*NCNT+k] = 1'b1;
              live_m[c][k] = SAT ? MAXV : 0;
            end else begin
              live_m[c][k] = live_m[c][k] + 1;
            end
          end
        end
        if ((hit & miss) != '0) proto_m = 1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [CNT_W-1:0] e;
    if (rst) last_data_m = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_data_m = e;
      chk("model_rd_ack", rd_ack, 1);
      chk("model_rd_data", rd_data, e);
    end else begin
      chk("model_rd_ack_idle", rd_ack, 0);
      chk("model_rd_data_hold", rd_data, last_data_m);
    end
    chk("model_snap_done", snap_done, snapd_m);
    chk("model_ovf", ovf, ovf_m);
    chk("model_proto_err", proto_err, proto_m);
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1ns after a rising edge.
  task automatic step(input logic [NUM_CH-1:0] r, w, h, m,
                      input logic cv, input logic [3:0] cmd,
                      input logic req, input logic [CH_W-1:0] sch,
                      input logic [1:0] scnt);
    rd = r; wr = w; hit = h; miss = m;
    cmd_valid = cv; n = cmd; rd_req = req; sel_ch = sch; sel_cnt = scnt;
    @(posedge clk); #1;
    rd = '0; wr = '0; hit = '0; miss = '0;
    cmd_valid = 1'b0; n = '0; rd_req = 1'b0;
  endtask

  task automatic ev(input logic [NUM_CH-1:0] r, w, h, m);
    step(r, w, h, m, 1'b0, 4'd0, 1'b0, '0, '0);
  endtask

  task automatic cmd(input logic [3:0] c);
    step('0, '0, '0, '0, 1'b1, c, 1'b0, '0, '0);
  endtask

  task automatic snap_chk(input string name);
    cmd(4'd9);
    @(negedge clk);
    chk(name, snap_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic read_chk(input string name, input int ch, input int cnt, input longint exp);
    step('0, '0, '0, '0, 1'b0, 4'd0, 1'b1, CH_W'(ch), 2'(cnt));
    @(negedge clk);
    chk({name, "_ack"}, rd_ack, 1);
    chk(name, rd_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and full readback, including an out-of-range channel.
    chk("reset_ovf", ovf, 0);
    chk("reset_proto", proto_err, 0);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        read_chk("reset_read", c, k, 0);

    // Basic counting and snapshot.
    repeat (5) ev(3'b000, 3'b000, 3'b001, 3'b000);
    repeat (3) ev(3'b000, 3'b000, 3'b000, 3'b010);
    repeat (2) ev(3'b000, 3'b010, 3'b000, 3'b000);
    cmd(4'd5);
    snap_chk("snap_done_1");
    read_chk("rd_ch0_hit", 0, 2, 5);
    read_chk("rd_ch1_miss", 1, 3, 3);
    read_chk("rd_ch1_wr", 1, 1, 2);
    read_chk("rd_ch0_rd", 0, 0, 0);
    read_chk("rd_ch2_hit", 2, 2, 0);
    read_chk("rd_ch3_oob", 3, 2, 0);

    // Event and snapshot in the same cycle; readback during a snapshot.
    step(3'b001, '0, '0, '0, 1'b1, 4'd9, 1'b0, '0, '0);
    step('0, '0, '0, '0, 1'b1, 4'd9, 1'b1, 2'd0, 2'd0);
    @(negedge clk);
    chk("rd_during_snap", rd_data, 0);
    @(posedge clk); #1;
    read_chk("rd_after_second_snap", 0, 0, 1);

    // Hit+miss together, then clear with a concurrent event.
    ev('0, '0, 3'b001, 3'b001);
    @(negedge clk);
    chk("proto_set", proto_err, 1);
    @(posedge clk); #1;
    snap_chk("snap_done_2");
    read_chk("rd_hit_proto", 0, 2, 6);
    read_chk("rd_miss_proto", 0, 3, 1);
    step('0, '0, 3'b001, '0, 1'b1, 4'd8, 1'b0, '0, '0);
    snap_chk("snap_done_3");
    chk("proto_cleared", proto_err, 0);
    read_chk("rd_clr_hit", 0, 2, 0);
    read_chk("rd_clr_miss", 0, 3, 0);
    read_chk("rd_clr_ch1_miss", 1, 3, 0);

    // Overflow of ch0 hit counter.
    repeat (255) ev('0, '0, 3'b001, '0);
    @(negedge clk);
    chk("ovf_before_wrap", ovf, 0);
    @(posedge clk); #1;
    ev('0, '0, 3'b001, '0);
    snap_chk("snap_done_ovf");
    chk("ovf_bit2", ovf[2], 1);
    chk("ovf_others", ovf & ~12'h004, 0);
    read_chk("rd_ovf_value", 0, 2, SAT ? 255 : 0);

    // Asynchronous reset with a readback in flight.
    repeat (10) ev(3'b010, '0, '0, '0);
    rd_req = 1'b1; sel_ch = 2'd0; sel_cnt = 2'd2;
    @(posedge clk); #1;
    rd_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_drops_ack", rd_ack, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1 rst = 1'b0;
    snap_chk("snap_done_rst");
    read_chk("rd_after_rst_ch1", 1, 0, 0);
    read_chk("rd_after_rst_ch0", 0, 2, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
